uart_deserializer_param: RTL and testbench

UART_DESERIALIZER_PARAM -- requirements
Module: uart_deserializer_param

---
 rtl/uart_deserializer_param.sv | 112 +++++++++++
 tb/tb_uart_deserializer_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_deserializer_param.sv
// uart_deserializer_param: shifts sampled UART bits into DATA_WIDTH-bit words with valid/ack handoff.
// Optional macro DESER_PARITY_EN adds Par_Bit (XOR of the held word). Rev 1.0
`default_nettype none

module uart_deserializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1
) (
  input  logic                                  CLK,
  input  logic                                  Reset,
  input  logic                                  sampled_data,
  input  logic                                  sampled,
  input  logic                                  deser_en,
  input  logic                                  Data_Ack,
  output logic [DATA_WIDTH-1:0]                 P_Data,
  output logic                                  Data_Valid,
  output logic                                  Overrun,
  output logic [$clog2(DATA_WIDTH+1)-1:0]       Bit_Cnt
`ifdef DESER_PARITY_EN
  ,
  output logic                                  Par_Bit
`endif
);

  localparam int CW = $clog2(DATA_WIDTH+1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic [CW-1:0]         r_cnt;
  logic                  r_valid;
  logic                  r_ovr;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_load;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_shift_nxt = {sampled_data, r_shift[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], sampled_data};
    end
  endgenerate

  assign w_accept   = deser_en & sampled;
  assign w_complete = w_accept && (r_cnt == CW'(DATA_WIDTH - 1));
  // A completing word is only kept when the holding register is free or being drained this cycle.
  assign w_load     = w_complete && (!r_valid || Data_Ack);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!deser_en || w_complete) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (sampled) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_pdata <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_complete && !w_load;
      if (w_load) begin
        r_pdata <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (Data_Ack) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic r_par_acc;
  logic r_par_bit;
  logic w_par_nxt;

  assign w_par_nxt = r_par_acc ^ sampled_data;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_par_acc <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      if (!deser_en || w_complete) begin
        r_par_acc <= 1'b0;
      end else if (sampled) begin
        r_par_acc <= w_par_nxt;
      end
      if (w_load) begin
        r_par_bit <= w_par_nxt;
      end
    end
  end

  assign Par_Bit = r_par_bit;
`endif

  assign P_Data     = r_pdata;
  assign Data_Valid = r_valid;
  assign Overrun    = r_ovr;
  assign Bit_Cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_deserializer_param.sv
// tb_uart_deserializer_param: four configurations on shared stimulus, scoreboard-checked against a word-level model.
`default_nettype none

module tb_uart_deserializer_param;

  localparam int ND = 4;
  localparam int PW [ND] = '{8, 8, 5, 9};
  localparam int PL [ND] = '{1, 0, 1, 0};

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic sampled_data = 1'b0;
  logic sampled = 1'b0;
  logic deser_en = 1'b0;
  logic Data_Ack = 1'b0;

  logic [8:0] pd [ND];
  logic       dv [ND];
  logic       ov [ND];
  logic [3:0] bc [ND];
  logic       pb [ND];

  always #5 CLK = ~CLK;

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int DW = PW[g];
      logic [DW-1:0]              pdl;
      logic [$clog2(DW+1)-1:0]    bcl;
      logic                       dvl;
      logic                       ovl;
`ifdef DESER_PARITY_EN
      logic                       pbl;
`endif
      uart_deserializer_param #(.DATA_WIDTH(DW), .LSB_FIRST(PL[g])) u_dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .sampled_data (sampled_data),
        .sampled      (sampled),
        .deser_en     (deser_en),
        .Data_Ack     (Data_Ack),
        .P_Data       (pdl),
        .Data_Valid   (dvl),
        .Overrun      (ovl),
        .Bit_Cnt      (bcl)
`ifdef DESER_PARITY_EN
        ,
        .Par_Bit      (pbl)
`endif
      );
      assign pd[g] = 9'(pdl);
      assign bc[g] = 4'(bcl);
      assign dv[g] = dvl;
      assign ov[g] = ovl;
`ifdef DESER_PARITY_EN
      assign pb[g] = pbl;
`else
      assign pb[g] = 1'b0;
`endif
    end
  endgenerate

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a list of received bits per configuration, folded into a word on completion.
  logic [9:0] wq [ND][$];
  int         ovr_pend [ND];
  int         mcnt [ND];
  logic [8:0] mbits [ND];
  bit         mvalid [ND];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) begin
      wq[k].delete();
      ovr_pend[k] = 0;
      mcnt[k]     = 0;
      mbits[k]    = '0;
      mvalid[k]   = 1'b0;
    end
  endtask

  task automatic cyc(input logic s, input logic d, input logic en, input logic ack);
    sampled = s; sampled_data = d; deser_en = en; Data_Ack = ack;
    for (int k = 0; k < ND; k++) begin
      bit         done;
      logic [8:0] w;
      done = 1'b0;
      w    = '0;
      if (!en) begin
        mcnt[k] = 0;
      end else if (s) begin
        mbits[k][mcnt[k]] = d;
        mcnt[k]++;
        if (mcnt[k] == PW[k]) begin
          done    = 1'b1;
          mcnt[k] = 0;
        end
      end
      if (done) begin
        for (int i = 0; i < PW[k]; i++) begin
          if (PL[k] != 0) w[i] = mbits[k][i];
          else            w[PW[k]-1-i] = mbits[k][i];
        end
        if (mvalid[k] && !ack) ovr_pend[k]++;
        else begin
          wq[k].push_back({^w, w});
          mvalid[k] = 1'b1;
        end
      end else if (ack) begin
        mvalid[k] = 1'b0;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic send_word(input logic [8:0] w, input int n, input int gap, input logic ack_last);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, w[i], 1'b1, (i == n - 1) ? ack_last : 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s_pdata%0d", tag, k), int'(pd[k]), 0);
      chk($sformatf("%s_valid%0d", tag, k), int'(dv[k]), 0);
      chk($sformatf("%s_ovr%0d", tag, k), int'(ov[k]), 0);
      chk($sformatf("%s_cnt%0d", tag, k), int'(bc[k]), 0);
    end
  endtask

  // Monitor: an Overrun pulse consumes one expected drop; a valid/ack handshake consumes one expected word.
  always @(negedge CLK) begin
    if (Reset) begin
      for (int k = 0; k < ND; k++) begin
        logic [9:0] e;
        if (ov[k]) begin
          n_cmp++;
          if (ovr_pend[k] == 0) begin
            n_err++;
            $display("FAIL overrun dut%0d: got pulse expected none", k);
          end else ovr_pend[k]--;
        end
        if (dv[k] && Data_Ack) begin
          n_cmp++;
          if (wq[k].size() == 0) begin
            n_err++;
            $display("FAIL handshake dut%0d: got word %0h expected no word", k, pd[k]);
          end else begin
            e = wq[k].pop_front();
            if (pd[k] != e[8:0]) begin
              n_err++;
              $display("FAIL hs_data dut%0d: got %0h expected %0h", k, pd[k], e[8:0]);
            end
`ifdef DESER_PARITY_EN
            else if (pb[k] != e[9]) begin
              n_err++;
              $display("FAIL hs_parity dut%0d: got %0b expected %0b", k, pb[k], e[9]);
            end
`endif
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    #1 Reset = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;

    // LSB-first and MSB-first capture of 1,0,1,1,0,0,1,0 with 16-cycle strobe spacing
    send_word(9'h04D, 3, 16, 1'b0);
    chk("cnt_after3", int'(bc[0]), 3);
    send_word(9'h009, 5, 16, 1'b0);
    chk("lsb_pdata", int'(pd[0]), 'h4D);
    chk("lsb_valid", int'(dv[0]), 1);
    chk("msb_pdata", int'(pd[1]), 'hB2);
    chk("cnt_wrap", int'(bc[0]), 0);
`ifdef DESER_PARITY_EN
    chk("lsb_par", int'(pb[0]), 0);
`endif

    // Abort after five bits, strobe coincident with deser_en low
    send_word(9'h01F, 5, 2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_cnt", int'(bc[0]), 0);
    chk("abort_pdata", int'(pd[0]), 'h4D);
    send_word(9'h0A5, 8, 2, 1'b1);
    chk("after_abort", int'(pd[0]), 'hA5);

    // Overrun without ack, then completion coincident with ack
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    send_word(9'h04D, 8, 2, 1'b0);
    send_word(9'h011, 8, 2, 1'b0);
    chk("ovr_pdata", int'(pd[0]), 'h4D);
    chk("ovr_pulse", int'(ov[0]), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_once", int'(ov[0]), 0);
    send_word(9'h011, 8, 2, 1'b1);
    chk("ack_pdata", int'(pd[0]), 'h11);
    chk("ack_no_ovr", int'(ov[0]), 0);
    chk("ack_valid", int'(dv[0]), 1);

    // Narrow and wide words
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(9'h013, 5, 2, 1'b0);
    chk("w5_pdata", int'(pd[2]), 'h13);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(9'h1FF, 9, 2, 1'b0);
    chk("w9_pdata", int'(pd[3]), 'h1FF);
`ifdef DESER_PARITY_EN
    chk("w9_par", int'(pb[3]), 1);
`endif

    // Asynchronous reset in the middle of a word
    send_word(9'h007, 3, 2, 1'b0);
    sampled = 1'b0; deser_en = 1'b0; Data_Ack = 1'b0;
    Reset = 1'b0;
    model_clear();
    #2 chk_all_zero("midreset");
    @(posedge CLK); #1 Reset = 1'b1;
    send_word(9'h03C, 8, 2, 1'b0);
    chk("post_reset", int'(pd[0]), 'h3C);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic en, s, d, ack;
      en  = ($urandom_range(0, 99) >= 3);
      s   = ($urandom_range(0, 2) == 0);
      d   = 1'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      cyc(s, d, en, ack);
    end

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("leftover_words%0d", k), wq[k].size(), 0);
      chk($sformatf("leftover_ovr%0d", k), ovr_pend[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
